// File: rtl/bs_dec_pkg.sv
`default_nettype none
// bs_dec_pkg -- shared widths, FSM states, fixed-Huffman code ranges and
// length/distance tables for the fixed-Huffman block decoder (rev 1.0).
package bs_dec_pkg;

  // Widths shared with the bitstream writer
  localparam int PKG_LIT_DAT_WD = 8;
  localparam int PKG_LEN_DAT_WD = 7;
  localparam int PKG_DIS_DAT_WD = 7;
  localparam int PKG_DATA_WD    = 32;
  localparam int PKG_BUF_WD     = 64;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_HDR     = 4'd1,
    ST_SYM     = 4'd2,
    ST_LEN_EXT = 4'd3,
    ST_DIS_SYM = 4'd4,
    ST_DIS_EXT = 4'd5,
    ST_OUT     = 4'd6,
    ST_DONE    = 4'd7,
    ST_ERR     = 4'd8
  } dec_state_e;

  localparam int HDR_BITS      = 3;
  localparam int DIS_CODE_BITS = 5;
  localparam int PEEK_WD       = 9;
  localparam int USE_WD        = 4;

  // Fixed-Huffman literal/length code ranges, expressed in code order
  localparam logic [6:0] SYM7_MAX   = 7'b0010111;
  localparam logic [7:0] SYM8A_LO   = 8'b00110000;
  localparam logic [7:0] SYM8A_HI   = 8'b10111111;
  localparam logic [7:0] SYM8B_LO   = 8'b11000000;
  localparam logic [7:0] SYM8B_HI   = 8'b11000111;
  localparam logic [8:0] SYM9_LO    = 9'b110010000;
  localparam logic [8:0] SYM8B_BASE = 9'd280;
  localparam logic [8:0] SYM9_BASE  = 9'd144;
  localparam logic [8:0] SYM_EOB    = 9'd256;
  localparam logic [8:0] SYM_LEN_LO = 9'd257;
  localparam logic [8:0] SYM_LEN_HI = 9'd276;

  localparam logic [4:0] DIS_CODE_MAX = 5'd11;
  localparam logic [7:0] MAX_LEN      = 8'd64;

  // Length table indexed by symbol - 257
  function automatic logic [6:0] len_base(input logic [4:0] idx);
    logic [6:0] b;
    case (idx)
      5'd0:  b = 7'd3;   5'd1:  b = 7'd4;   5'd2:  b = 7'd5;   5'd3:  b = 7'd6;
      5'd4:  b = 7'd7;   5'd5:  b = 7'd8;   5'd6:  b = 7'd9;   5'd7:  b = 7'd10;
      5'd8:  b = 7'd11;  5'd9:  b = 7'd13;  5'd10: b = 7'd15;  5'd11: b = 7'd17;
      5'd12: b = 7'd19;  5'd13: b = 7'd23;  5'd14: b = 7'd27;  5'd15: b = 7'd31;
      5'd16: b = 7'd35;  5'd17: b = 7'd43;  5'd18: b = 7'd51;  5'd19: b = 7'd59;
      default: b = 7'd0;
    endcase
    return b;
  endfunction

  function automatic logic [2:0] len_ebits(input logic [4:0] idx);
    logic [4:0] grp;
    grp = (idx - 5'd8) >> 2;
    return (idx < 5'd8) ? 3'd0 : 3'(grp + 5'd1);
  endfunction

  function automatic logic [6:0] dis_base(input logic [3:0] code);
    logic [6:0] b;
    case (code)
      4'd0: b = 7'd1;   4'd1: b = 7'd2;   4'd2:  b = 7'd3;   4'd3:  b = 7'd4;
      4'd4: b = 7'd5;   4'd5: b = 7'd7;   4'd6:  b = 7'd9;   4'd7:  b = 7'd13;
      4'd8: b = 7'd17;  4'd9: b = 7'd25;  4'd10: b = 7'd33;  4'd11: b = 7'd49;
      default: b = 7'd0;
    endcase
    return b;
  endfunction

  function automatic logic [2:0] dis_ebits(input logic [3:0] code);
    logic [3:0] half;
    half = (code >> 1) - 4'd1;
    return (code < 4'd4) ? 3'd0 : 3'(half);
  endfunction

  function automatic logic [3:0] low_mask(input logic [2:0] n);
    logic [4:0] m;
    m = (5'd1 << n) - 5'd1;
    return m[3:0];
  endfunction

  // Huffman codes are packed MSB-first, so the LSB-first buffer is reversed
  function automatic logic [8:0] rev9(input logic [8:0] v);
    logic [8:0] r;
    for (int k = 0; k < 9; k++) r[8-k] = v[k];
    return r;
  endfunction

  function automatic logic [4:0] rev5(input logic [4:0] v);
    logic [4:0] r;
    for (int k = 0; k < 5; k++) r[4-k] = v[k];
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bs_dec_bitbuf.sv
`default_nettype none
// bs_dec_bitbuf -- byte-swapping 64-bit LSB-first bit buffer with word append,
// bit consume and peek for the fixed-Huffman decoder (rev 1.0).
module bs_dec_bitbuf #(
  parameter int DATA_WD = 32,
  parameter int BUF_WD  = 64,
  parameter int CNT_WD  = $clog2(BUF_WD) + 1,
  parameter int PEEK_WD = 9,
  parameter int USE_WD  = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               clr_i,
  input  logic               act_i,
  input  logic               val_i,
  input  logic [DATA_WD-1:0] dat_i,
  input  logic [USE_WD-1:0]  use_i,
  output logic               rdy_o,
  output logic [PEEK_WD-1:0] peek_o,
  output logic [CNT_WD-1:0]  cnt_o
);

  logic [DATA_WD-1:0] dat_swp;
  logic [BUF_WD-1:0]  bits_q, bits_d;
  logic [CNT_WD-1:0]  cnt_q, cnt_d, cnt_rem;
  logic               acc;

  // Stream byte 0 sits in the top byte of the word; it must land at bit 0
  for (genvar gi = 0; gi < DATA_WD / 8; gi++) begin : g_swap
    assign dat_swp[8*gi +: 8] = dat_i[DATA_WD - 8*(gi+1) +: 8];
  end

  assign rdy_o  = act_i & ~clr_i & (cnt_q <= CNT_WD'(DATA_WD));
  assign acc    = val_i & rdy_o;
  assign peek_o = bits_q[PEEK_WD-1:0];
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_rem = cnt_q - CNT_WD'(use_i);
    bits_d  = bits_q >> use_i;
    cnt_d   = cnt_rem;
    if (acc) begin
      bits_d = bits_d | ({{(BUF_WD-DATA_WD){1'b0}}, dat_swp} << cnt_rem);
      cnt_d  = cnt_rem + CNT_WD'(DATA_WD);
    end
    if (clr_i) begin
      bits_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bits_q <= '0;
      cnt_q  <= '0;
    end else begin
      bits_q <= bits_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bs_dec_fixed.sv
`default_nettype none
// bs_dec_fixed -- single final fixed-Huffman deflate block decoder producing
// literal / match / end-of-block tokens from a 32-bit word stream (rev 1.0).
module bs_dec_fixed
  import bs_dec_pkg::*;
#(
  parameter int LIT_DAT_WD = PKG_LIT_DAT_WD,
  parameter int LEN_DAT_WD = PKG_LEN_DAT_WD,
  parameter int DIS_DAT_WD = PKG_DIS_DAT_WD,
  parameter int DATA_WD    = PKG_DATA_WD,
  parameter int BUF_WD     = PKG_BUF_WD
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start_i,
  input  logic                  val_i,
  input  logic [DATA_WD-1:0]    dat_i,
  output logic                  rdy_o,
  output logic                  val_o,
  input  logic                  rdy_i,
  output logic                  flg_lit_o,
  output logic [LIT_DAT_WD-1:0] lit_dat_o,
  output logic [LEN_DAT_WD-1:0] len_dat_o,
  output logic [DIS_DAT_WD-1:0] dis_dat_o,
  output logic                  lst_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int CNT_WD = $clog2(BUF_WD) + 1;

  dec_state_e            state_q, state_d;
  logic                  flg_lit_q, flg_lit_d;
  logic [LIT_DAT_WD-1:0] lit_dat_q, lit_dat_d;
  logic [LEN_DAT_WD-1:0] len_dat_q, len_dat_d;
  logic [DIS_DAT_WD-1:0] dis_dat_q, dis_dat_d;
  logic                  lst_q, lst_d;
  logic [4:0]            len_idx_q, len_idx_d;
  logic [3:0]            dis_code_q, dis_code_d;

  logic [PEEK_WD-1:0] peek;
  logic [CNT_WD-1:0]  cnt;
  logic [USE_WD-1:0]  use_bits;
  logic               clr;
  logic               act;

  logic [8:0] code9;
  logic [7:0] code8;
  logic [6:0] code7;
  logic [8:0] sym;
  logic [3:0] sym_len;
  logic [2:0] len_eb, dis_eb;
  logic [3:0] len_ext, dis_ext;
  logic [7:0] len_sum, dis_sum;
  logic [4:0] dis_code5;
  logic [8:0] len_idx_full;

  assign act = (state_q == ST_HDR) || (state_q == ST_SYM) || (state_q == ST_LEN_EXT) ||
               (state_q == ST_DIS_SYM) || (state_q == ST_DIS_EXT);

  bs_dec_bitbuf #(
    .DATA_WD (DATA_WD),
    .BUF_WD  (BUF_WD),
    .CNT_WD  (CNT_WD),
    .PEEK_WD (PEEK_WD),
    .USE_WD  (USE_WD)
  ) u_bitbuf (
    .clk    (clk),
    .rstn   (rstn),
    .clr_i  (clr),
    .act_i  (act),
    .val_i  (val_i),
    .dat_i  (dat_i),
    .use_i  (use_bits),
    .rdy_o  (rdy_o),
    .peek_o (peek),
    .cnt_o  (cnt)
  );

  assign code9 = rev9(peek);
  assign code8 = code9[8:1];
  assign code7 = code9[8:2];

  // Code length is chosen from its own prefix, so zero bits above cnt never
  // pick a shorter code than the real one; the stall check covers the rest.
  always_comb begin
    sym     = 9'd0;
    sym_len = 4'd9;
    if (code7 <= SYM7_MAX) begin
      sym     = SYM_EOB + 9'(code7);
      sym_len = 4'd7;
    end else if ((code8 >= SYM8A_LO) && (code8 <= SYM8A_HI)) begin
      sym     = 9'(code8 - SYM8A_LO);
      sym_len = 4'd8;
    end else if ((code8 >= SYM8B_LO) && (code8 <= SYM8B_HI)) begin
      sym     = SYM8B_BASE + 9'(code8[2:0]);
      sym_len = 4'd8;
    end else begin
      sym     = SYM9_BASE + (code9 - SYM9_LO);
      sym_len = 4'd9;
    end
  end

  assign len_idx_full = sym - SYM_LEN_LO;
  assign len_eb       = len_ebits(len_idx_q);
  assign len_ext      = peek[3:0] & low_mask(len_eb);
  assign len_sum      = {1'b0, len_base(len_idx_q)} + {4'd0, len_ext};
  assign dis_code5    = rev5(peek[4:0]);
  assign dis_eb       = dis_ebits(dis_code_q);
  assign dis_ext      = peek[3:0] & low_mask(dis_eb);
  assign dis_sum      = {1'b0, dis_base(dis_code_q)} + {4'd0, dis_ext};

  always_comb begin
    state_d    = state_q;
    flg_lit_d  = flg_lit_q;
    lit_dat_d  = lit_dat_q;
    len_dat_d  = len_dat_q;
    dis_dat_d  = dis_dat_q;
    lst_d      = lst_q;
    len_idx_d  = len_idx_q;
    dis_code_d = dis_code_q;
    use_bits   = '0;
    clr        = 1'b0;

    case (state_q)
      ST_HDR: begin
        if (cnt >= CNT_WD'(HDR_BITS)) begin
          use_bits = USE_WD'(HDR_BITS);
          state_d  = (peek[0] && peek[1] && !peek[2]) ? ST_SYM : ST_ERR;
        end
      end
      ST_SYM: begin
        if (cnt >= CNT_WD'(sym_len)) begin
          use_bits = sym_len;
          if (sym < SYM_EOB) begin
            flg_lit_d = 1'b1;
            lit_dat_d = LIT_DAT_WD'(sym[7:0]);
            len_dat_d = '0;
            dis_dat_d = '0;
            lst_d     = 1'b0;
            state_d   = ST_OUT;
          end else if (sym == SYM_EOB) begin
            flg_lit_d = 1'b0;
            lit_dat_d = '0;
            len_dat_d = '0;
            dis_dat_d = '0;
            lst_d     = 1'b1;
            state_d   = ST_OUT;
          end else if (sym <= SYM_LEN_HI) begin
            len_idx_d = len_idx_full[4:0];
            state_d   = ST_LEN_EXT;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_LEN_EXT: begin
        if (cnt >= CNT_WD'(len_eb)) begin
          use_bits  = USE_WD'(len_eb);
          len_dat_d = LEN_DAT_WD'(len_sum);
          state_d   = (len_sum > MAX_LEN) ? ST_ERR : ST_DIS_SYM;
        end
      end
      ST_DIS_SYM: begin
        if (cnt >= CNT_WD'(DIS_CODE_BITS)) begin
          use_bits   = USE_WD'(DIS_CODE_BITS);
          dis_code_d = dis_code5[3:0];
          state_d    = (dis_code5 > DIS_CODE_MAX) ? ST_ERR : ST_DIS_EXT;
        end
      end
      ST_DIS_EXT: begin
        if (cnt >= CNT_WD'(dis_eb)) begin
          use_bits  = USE_WD'(dis_eb);
          dis_dat_d = DIS_DAT_WD'(dis_sum);
          flg_lit_d = 1'b0;
          lit_dat_d = '0;
          lst_d     = 1'b0;
          state_d   = ST_OUT;
        end
      end
      ST_OUT: begin
        if (rdy_i) state_d = lst_q ? ST_DONE : ST_SYM;
      end
      ST_DONE: clr = 1'b1;
      default: ;
    endcase

    // A new start aborts whatever is in flight, including a pending token
    if (start_i) begin
      state_d   = ST_HDR;
      clr       = 1'b1;
      use_bits  = '0;
      flg_lit_d = 1'b0;
      lit_dat_d = '0;
      len_dat_d = '0;
      dis_dat_d = '0;
      lst_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      flg_lit_q  <= 1'b0;
      lit_dat_q  <= '0;
      len_dat_q  <= '0;
      dis_dat_q  <= '0;
      lst_q      <= 1'b0;
      len_idx_q  <= '0;
      dis_code_q <= '0;
    end else begin
      state_q    <= state_d;
      flg_lit_q  <= flg_lit_d;
      lit_dat_q  <= lit_dat_d;
      len_dat_q  <= len_dat_d;
      dis_dat_q  <= dis_dat_d;
      lst_q      <= lst_d;
      len_idx_q  <= len_idx_d;
      dis_code_q <= dis_code_d;
    end
  end

  assign val_o     = (state_q == ST_OUT);
  assign err_o     = (state_q == ST_ERR);
  assign done_o    = val_o & rdy_i & lst_q;
  assign flg_lit_o = flg_lit_q;
  assign lit_dat_o = lit_dat_q;
  assign len_dat_o = len_dat_q;
  assign dis_dat_o = dis_dat_q;
  assign lst_o     = lst_q;

endmodule
`default_nettype wire

// File: doc/bs_dec_fixed.md
Name: bs_dec_fixed

Overview:
- Fixed-Huffman deflate block decoder; the receive-side counterpart of the bitstream writer.
- Consumes the raw deflate bitstream as 32-bit words and emits literal/length/distance tokens on the same token fields the writer accepts (flg_lit, lit_dat, len_dat, dis_dat, lst).
- Used in loop-back checking: writer output is fed back and the tokens are compared against the writer's input.
- Supports one final fixed-Huffman block (BFINAL=1, BTYPE=01), lengths 3..64, distances 1..64.

Parameters:
- LIT_DAT_WD, 8, literal width.
- LEN_DAT_WD, 7, match length width (max 64).
- DIS_DAT_WD, 7, match distance width (max 64).
- DATA_WD, 32, input word width.
- BUF_WD, 64, bit buffer width (2*DATA_WD).

Ports:
- clk  in  1  clock
- rstn  in  1  reset; one clock; reset is asynchronous and active-low
- start_i  in  1  one-cycle pulse; clears buffer, enters HDR
- val_i  in  1  input word valid
- dat_i  in  DATA_WD  input word; stream byte 0 = dat_i[31:24]; bits LSB-first within each byte
- rdy_o  out  1  word accepted when val_i & rdy_o
- val_o  out  1  token valid
- rdy_i  in  1  downstream ready; token consumed when val_o & rdy_i
- flg_lit_o  out  1  1 = literal, 0 = match
- lit_dat_o  out  LIT_DAT_WD  literal byte
- len_dat_o  out  LEN_DAT_WD  match length
- dis_dat_o  out  DIS_DAT_WD  match distance
- lst_o  out  1  end-of-block marker token (symbol 256); all data fields 0
- done_o  out  1  one-cycle pulse when the lst token is consumed
- err_o  out  1  sticky error; cleared by start_i or reset

Behaviour:
- Reset: all outputs 0; state IDLE; bit count 0; buffer 0.
- Bit buffer:
  - Byte-swap dat_i, then append it above the current bit count.
  - rdy_o = 1 in HDR/SYM/LEN_EXT/DIS_SYM/DIS_EXT when count <= 32; otherwise 0.
  - Consume from the LSB. Append and consume may happen in the same cycle: new count = count + 32*acc - used.
- FSM: IDLE -> HDR -> SYM -> {OUT | LEN_EXT} ; LEN_EXT -> DIS_SYM -> DIS_EXT -> OUT ; OUT -> SYM, or OUT -> DONE after lst. ERR and DONE wait for start_i.
- Each decode state stalls until count >= the bits it needs. Otherwise it completes in one cycle.
- HDR: needs 3 bits. Requires BFINAL=1 and BTYPE=01 (bit1=1, bit2=0); anything else -> ERR.
- SYM: peek 9 bits, bit-reversed into code order.
  - 7-bit 0000000-0010111 -> symbols 256-279.
  - 8-bit 00110000-10111111 -> symbols 0-143.
  - 8-bit 11000000-11000111 -> symbols 280-287.
  - 9-bit 110010000-111111111 -> symbols 144-255.
  - Symbol <256 -> literal token.
  - Symbol 256 -> lst token.
  - Symbols 257..276 -> LEN_EXT.
  - Symbols >=277 -> ERR.
- LEN_EXT: extra bits are 0 for 257-264, 1 for 265-268, 2 for 269-272, 3 for 273-276. Extra bits are read LSB-first (not reversed).
  - Length = base + extra.
  - Length > 64 -> ERR (e.g. 276 with extra >= 6).
- DIS_SYM: 5-bit code, bit-reversed. Codes 0..11 allowed; >11 -> ERR.
- DIS_EXT: extra bits 0/0/0/0/1/1/2/2/3/3/4/4 for codes 0..11. Bases are 1,2,3,4,5,7,9,13,17,25,33,49.
- OUT: val_o held with all fields stable until rdy_i. Next decode begins the cycle after consumption, giving one token per 2 cycles for literals.
- DONE: done_o pulses the cycle the lst token is consumed. Remaining buffered bits are discarded and rdy_o = 0.
- ERR: err_o = 1, val_o = 0, rdy_o = 0.
- start_i in any state has priority: aborts, drops any pending token, clears buffer and err_o, goes to HDR.
- val_i is ignored outside the active states.

Decomposition:
- Shared package/header holds:
  - FSM state encodings.
  - Fixed-Huffman code range constants.
  - Length base/extra-bit tables (257..276).
  - Distance base/extra-bit tables (0..11).
  - Width constants shared with the writer.
- One sub-module, bs_dec_bitbuf: byte swap, 64-bit shift buffer, count, rdy_o, and the peek/consume interface.

Test Plan:
- Stream word 0x73040000 ("A") -> tokens lit 0x41, then lst; done_o pulses; err_o = 0.
- Stream "A" + symbol 257 + dist code 0 + EOB -> lit 0x41, then match len 3 dis 1, then lst.
- Symbol 276 with extra 5, dist code 11 with extra 15 -> match len 64 dis 64. Same stream with length extra 6 -> err_o = 1, no token.
- Header BTYPE=10 (byte 0x05) -> err_o = 1 after 3 bits; rdy_o = 0. A following start_i clears err_o.
- rdy_i held 0 for 5 cycles on the first token -> token fields stable, no token lost. val_i gaps between words -> decode stalls, output unchanged.
- start_i mid-stream while val_o is high -> token dropped, buffer cleared. A fresh 0x73040000 decodes correctly.
